// File: rtl/fulladd_pkg.sv
// Shared definitions for the full-adder response checker: state encoding,
// coverage-space sizing and the reference sum.
package fulladd_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      COVERED = 2'd2
   } fa_state_e;

   localparam int MAX_WIDTH = 3;

   // One coverage bit per {a,b,cin} combination.
   function automatic int cov_bits(input int width);
      return 1 << (2 * width + 1);
   endfunction

   function automatic logic [MAX_WIDTH:0] fa_expect(
      input logic [MAX_WIDTH-1:0] a,
      input logic [MAX_WIDTH-1:0] b,
      input logic                 cin
   );
      return {1'b0, a} + {1'b0, b} + {{MAX_WIDTH{1'b0}}, cin};
   endfunction

endpackage

// File: rtl/fulladd_cov_map.sv
// Input-space coverage bitmap: one sticky bit per {a,b,cin} index, plus a
// registered "everything seen" flag that moves together with the bitmap.
module fulladd_cov_map
   import fulladd_pkg::*;
#(
   parameter int COV_BITS = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clear_i,
   input  logic                        set_i,
   input  logic [$clog2(COV_BITS)-1:0] idx_i,
   output logic                        all_covered_o,
   output logic                        full_d_o
);

   logic [COV_BITS-1:0] bitmap_q;
   logic [COV_BITS-1:0] bitmap_d;
   logic                all_covered_q;

   always_comb begin
      bitmap_d = bitmap_q;
      if (set_i) begin
         bitmap_d[idx_i] = 1'b1;
      end
   end

   // Exposed so the controller can change state on the same edge that sets the last bit.
   assign full_d_o = &bitmap_d;

   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         bitmap_q      <= '0;
         all_covered_q <= 1'b0;
      end else begin
         bitmap_q      <= bitmap_d;
         all_covered_q <= full_d_o;
      end
   end

   assign all_covered_o = all_covered_q;

endmodule

// File: rtl/fulladd_checker.sv
// Full-adder response checker: compares observed {c,s} against a+b+cin per
// strobe, pulses pass/fail, counts errors, captures the first bad vector.
//
//  state   | meaning
//  IDLE    | no sample since reset/clear
//  RUN     | checking, some {a,b,cin} combination not yet seen
//  COVERED | checking, every combination seen (busy drops)
module fulladd_checker
   import fulladd_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int ERR_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 cin,
   input  logic [WIDTH-1:0]     s,
   input  logic                 c,
   output logic                 pass,
   output logic                 fail,
   output logic [ERR_W-1:0]     err_cnt,
   output logic [3*WIDTH+1:0]   first_fail,
   output logic                 all_covered,
   output logic                 busy
);

   localparam int COV_BITS = cov_bits(WIDTH);
   localparam int IDX_W    = 2 * WIDTH + 1;

   fa_state_e            state_q;
   logic                 pass_q;
   logic                 fail_q;
   logic [ERR_W-1:0]     err_cnt_q;
   logic [ERR_W-1:0]     err_cnt_d;
   logic [3*WIDTH+1:0]   first_fail_q;

   logic                 sample;
   logic                 match;
   logic                 cov_full_d;
   logic [WIDTH:0]       exp_sum;
   logic [IDX_W-1:0]     cov_idx;

   // A clear in the same cycle as a strobe discards the sample entirely.
   assign sample  = in_valid & ~clear;
   assign exp_sum = (WIDTH+1)'(fa_expect(MAX_WIDTH'(a), MAX_WIDTH'(b), cin));
   assign match   = ({c, s} == exp_sum);
   assign cov_idx = {a, b, cin};

   assign err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + ERR_W'(1);

   fulladd_cov_map #(
      .COV_BITS (COV_BITS)
   ) u_cov_map (
      .clk           (clk),
      .rst           (rst),
      .clear_i       (clear),
      .set_i         (sample),
      .idx_i         (cov_idx),
      .all_covered_o (all_covered),
      .full_d_o      (cov_full_d)
   );

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state_q      <= IDLE;
         pass_q       <= 1'b0;
         fail_q       <= 1'b0;
         err_cnt_q    <= '0;
         first_fail_q <= '0;
      end else begin
         pass_q <= sample & match;
         fail_q <= sample & ~match;
         if (sample && !match) begin
            err_cnt_q <= err_cnt_d;
            if (err_cnt_q == '0) begin
               first_fail_q <= {a, b, cin, s, c};
            end
         end
         case (state_q)
            IDLE:    if (sample) state_q <= cov_full_d ? COVERED : RUN;
            RUN:     if (cov_full_d) state_q <= COVERED;
            COVERED: state_q <= COVERED;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign pass       = pass_q;
   assign fail       = fail_q;
   assign err_cnt    = err_cnt_q;
   assign first_fail = first_fail_q;
   assign busy       = (state_q == RUN);

endmodule

// File: tb/tb_fulladd_checker.sv
// Bench for fulladd_checker: three instances (WIDTH=1/ERR_W=8, WIDTH=1/ERR_W=2,
// WIDTH=3/ERR_W=8) checked every cycle against an arithmetic reference model.
module tb_fulladd_checker;
   import fulladd_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, clear;

   logic       v1, cin1, c1;
   logic [0:0] a1, b1, s1;
   logic       v3, cin3, c3;
   logic [2:0] a3, b3, s3;

   logic        pass1, fail1, cov1, busy1;
   logic [7:0]  err1;
   logic [4:0]  ff1;
   logic        pass2, fail2, cov2, busy2;
   logic [1:0]  err2;
   logic [4:0]  ff2;
   logic        pass3, fail3, cov3, busy3;
   logic [7:0]  err3;
   logic [10:0] ff3;

   fulladd_checker #(.WIDTH(1), .ERR_W(8)) u_w1 (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(v1), .a(a1), .b(b1), .cin(cin1),
      .s(s1), .c(c1), .pass(pass1), .fail(fail1), .err_cnt(err1), .first_fail(ff1),
      .all_covered(cov1), .busy(busy1));

   fulladd_checker #(.WIDTH(1), .ERR_W(2)) u_e2 (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(v1), .a(a1), .b(b1), .cin(cin1),
      .s(s1), .c(c1), .pass(pass2), .fail(fail2), .err_cnt(err2), .first_fail(ff2),
      .all_covered(cov2), .busy(busy2));

   fulladd_checker #(.WIDTH(3), .ERR_W(8)) u_w3 (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(v3), .a(a3), .b(b3), .cin(cin3),
      .s(s3), .c(c3), .pass(pass3), .fail(fail3), .err_cnt(err3), .first_fail(ff3),
      .all_covered(cov3), .busy(busy3));

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   bit         m_pass1, m_fail1, m_cov1, m_busy1, m_started1;
   int         m_err1, m_err2, m_nseen1;
   logic [4:0] m_ff1;
   bit         seen1[8];
   bit         m_pass3, m_fail3, m_cov3, m_busy3, m_started3;
   int         m_err3, m_nseen3;
   logic [10:0] m_ff3;
   bit         seen3[128];

   typedef struct {
      bit a; bit b; bit cin; bit s; bit c;
      bit e_pass; bit e_fail; int e_err; bit e_cov;
   } vec_t;
   vec_t tbl[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_zero1();
      m_pass1 = 0; m_fail1 = 0; m_cov1 = 0; m_busy1 = 0; m_started1 = 0;
      m_err1 = 0; m_err2 = 0; m_nseen1 = 0; m_ff1 = '0;
      for (int i = 0; i < 8; i++) seen1[i] = 0;
   endtask

   task automatic model_zero3();
      m_pass3 = 0; m_fail3 = 0; m_cov3 = 0; m_busy3 = 0; m_started3 = 0;
      m_err3 = 0; m_nseen3 = 0; m_ff3 = '0;
      for (int i = 0; i < 128; i++) seen3[i] = 0;
   endtask

   task automatic model_tick();
      int tot, obs, idx;
      if (rst || clear) begin
         model_zero1();
         model_zero3();
      end else begin
         m_pass1 = 0; m_fail1 = 0;
         if (v1) begin
            tot = int'(a1) + int'(b1) + int'(cin1);
            obs = 2 * int'(c1) + int'(s1);
            if (tot == obs) m_pass1 = 1;
            else begin
               m_fail1 = 1;
               if (m_err1 == 0) m_ff1 = {a1, b1, cin1, s1, c1};
               if (m_err1 < 255) m_err1++;
               if (m_err2 < 3) m_err2++;
            end
            idx = 4 * int'(a1) + 2 * int'(b1) + int'(cin1);
            if (!seen1[idx]) begin seen1[idx] = 1; m_nseen1++; end
            m_started1 = 1;
         end
         m_cov1  = (m_nseen1 == 8);
         m_busy1 = m_started1 && !m_cov1;

         m_pass3 = 0; m_fail3 = 0;
         if (v3) begin
            tot = int'(a3) + int'(b3) + int'(cin3);
            obs = 8 * int'(c3) + int'(s3);
            if (tot == obs) m_pass3 = 1;
            else begin
               m_fail3 = 1;
               if (m_err3 == 0) m_ff3 = {a3, b3, cin3, s3, c3};
               if (m_err3 < 255) m_err3++;
            end
            idx = 16 * int'(a3) + 2 * int'(b3) + int'(cin3);
            if (!seen3[idx]) begin seen3[idx] = 1; m_nseen3++; end
            m_started3 = 1;
         end
         m_cov3  = (m_nseen3 == 128);
         m_busy3 = m_started3 && !m_cov3;
      end
   endtask

   task automatic check_all();
      chk("w1.pass", pass1, m_pass1);   chk("w1.fail", fail1, m_fail1);
      chk("w1.err", err1, m_err1);      chk("w1.first_fail", ff1, m_ff1);
      chk("w1.cov", cov1, m_cov1);      chk("w1.busy", busy1, m_busy1);
      chk("e2.pass", pass2, m_pass1);   chk("e2.fail", fail2, m_fail1);
      chk("e2.err", err2, m_err2);      chk("e2.first_fail", ff2, m_ff1);
      chk("e2.cov", cov2, m_cov1);      chk("e2.busy", busy2, m_busy1);
      chk("w3.pass", pass3, m_pass3);   chk("w3.fail", fail3, m_fail3);
      chk("w3.err", err3, m_err3);      chk("w3.first_fail", ff3, m_ff3);
      chk("w3.cov", cov3, m_cov3);      chk("w3.busy", busy3, m_busy3);
   endtask

   task automatic step();
      @(posedge clk);
      model_tick();
      @(negedge clk);
      check_all();
   endtask

   task automatic drive1(input bit v, input int av, input int bv, input int ci,
                         input int sv, input int cv);
      v1 = v;
      if (v) begin
         a1 = 1'(av); b1 = 1'(bv); cin1 = 1'(ci); s1 = 1'(sv); c1 = 1'(cv);
      end else begin
         a1 = 'x; b1 = 'x; cin1 = 'x; s1 = 'x; c1 = 'x;
      end
   endtask

   task automatic drive3(input bit v, input int av, input int bv, input int ci,
                         input int sv, input int cv);
      v3 = v;
      if (v) begin
         a3 = 3'(av); b3 = 3'(bv); cin3 = 1'(ci); s3 = 3'(sv); c3 = 1'(cv);
      end else begin
         a3 = 'x; b3 = 'x; cin3 = 'x; s3 = 'x; c3 = 'x;
      end
   endtask

   task automatic rand1();
      int av, bv, ci, tot, obs;
      if ($urandom_range(3) == 0) drive1(0, 0, 0, 0, 0, 0);
      else begin
         av = int'($urandom_range(1)); bv = int'($urandom_range(1)); ci = int'($urandom_range(1));
         tot = av + bv + ci;
         obs = ($urandom_range(3) == 0) ? (tot ^ int'($urandom_range(3, 1))) : tot;
         drive1(1, av, bv, ci, obs % 2, obs / 2);
      end
   endtask

   task automatic rand3();
      int av, bv, ci, tot, obs;
      if ($urandom_range(3) == 0) drive3(0, 0, 0, 0, 0, 0);
      else begin
         av = int'($urandom_range(7)); bv = int'($urandom_range(7)); ci = int'($urandom_range(1));
         tot = av + bv + ci;
         obs = ($urandom_range(3) == 0) ? (tot ^ int'($urandom_range(15, 1))) : tot;
         drive3(1, av, bv, ci, obs % 8, obs / 8);
      end
   endtask

   int exp4[5];

   initial begin
      rst = 1'b1; clear = 1'b0;
      drive1(0, 0, 0, 0, 0, 0);
      drive3(0, 0, 0, 0, 0, 0);
      step();
      step();
      chk("reset.err", err1, 0);
      chk("reset.busy", busy1, 0);
      rst = 1'b0;

      // Eight correct vectors covering the space, then two bad ones.
      for (int i = 0; i < 8; i++) begin
         tbl[i].a = i[2]; tbl[i].b = i[1]; tbl[i].cin = i[0];
         tbl[i].s = i[2] ^ i[1] ^ i[0];
         tbl[i].c = (i[2] & i[1]) | (i[2] & i[0]) | (i[1] & i[0]);
         tbl[i].e_pass = 1; tbl[i].e_fail = 0; tbl[i].e_err = 0; tbl[i].e_cov = (i == 7);
      end
      tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b1};
      tbl[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b1};
      for (int i = 0; i < 10; i++) begin
         drive1(1, int'(tbl[i].a), int'(tbl[i].b), int'(tbl[i].cin), int'(tbl[i].s), int'(tbl[i].c));
         step();
         chk("tbl.pass", pass1, tbl[i].e_pass);
         chk("tbl.fail", fail1, tbl[i].e_fail);
         chk("tbl.err", err1, tbl[i].e_err);
         chk("tbl.cov", cov1, tbl[i].e_cov);
         if (i == 7) chk("t2.busy_after_cover", busy1, 0);
      end
      chk("t3.first_fail", ff1, 5'b11010);

      // Reset held three cycles mid-stream, with a bad strobe present.
      rst = 1'b1;
      drive1(1, 1, 0, 0, 0, 1);
      step(); step(); step();
      rst = 1'b0;
      drive1(0, 0, 0, 0, 0, 0);
      step();
      chk("t1.err", err1, 0);       chk("t1.first_fail", ff1, 0);
      chk("t1.cov", cov1, 0);       chk("t1.busy", busy1, 0);
      chk("t1.pass", pass1, 0);     chk("t1.fail", fail1, 0);
      drive1(1, 0, 0, 0, 0, 0);
      step();
      chk("t1.bitmap_empty", cov1, 0);
      chk("t1.busy_run", busy1, 1);

      // Three passes, then clear together with a bad strobe.
      drive1(1, 1, 0, 0, 1, 0); step();
      drive1(1, 1, 1, 0, 0, 1); step();
      drive1(1, 0, 1, 1, 0, 1); step();
      clear = 1'b1;
      drive1(1, 0, 0, 0, 1, 1);
      step();
      clear = 1'b0;
      chk("t5.err", err1, 0);   chk("t5.fail", fail1, 0);
      chk("t5.cov", cov1, 0);   chk("t5.busy_idle", busy1, 0);

      // Saturation of the 2-bit counter.
      exp4 = '{1, 2, 3, 3, 3};
      for (int i = 0; i < 5; i++) begin
         drive1(1, 0, 0, 0, 1, 0);
         step();
         chk("t4.err_sat", err2, exp4[i]);
         chk("t4.fail", fail2, 1);
      end
      drive1(0, 0, 0, 0, 0, 0);
      step();
      chk("t4.fail_drop", fail2, 0);
      chk("t4.err_hold", err2, 3);

      // Widest operands: 7+7+1 = 4'b1111.
      drive3(1, 7, 7, 1, 7, 1);
      step();
      chk("t6.pass", pass3, 1);
      drive3(1, 7, 7, 1, 7, 0);
      step();
      chk("t6.fail", fail3, 1);
      chk("t6.err", err3, 1);
      drive3(0, 0, 0, 0, 0, 0);

      for (int n = 0; n < 1500; n++) begin
         rst   = ($urandom_range(399) == 0);
         clear = ($urandom_range(299) == 0);
         rand1();
         rand3();
         step();
      end

      rst = 1'b0; clear = 1'b0;
      drive1(0, 0, 0, 0, 0, 0);
      drive3(0, 0, 0, 0, 0, 0);
      step();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
